ps2_mouse_pos: RTL and testbench

PS2_MOUSE_POS -- requirements
Module: ps2_mouse_pos

---
 rtl/ps2_mouse_pos.sv | 168 ++++++++++++++++
 tb/tb_ps2_mouse_pos.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_pos.sv
// PS/2 mouse packet decoder: frames 3-byte packets and integrates clamped cursor position.
// Optional build macro PS2_DELTA_HALF_EN halves each non-overflowed delta before summing.
module ps2_mouse_pos #(
  parameter int X_MAX       = 63,
  parameter int Y_MAX       = 63,
  parameter int X_INIT      = 32,
  parameter int Y_INIT      = 32,
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic signed [8:0] PS2_Xdata,
  output logic signed [8:0] PS2_Ydata,
  output logic              btn_left,
  output logic              btn_right,
  output logic              pkt_valid
);

  localparam int unsigned SUM_W = 11;
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [GAP_W-1:0]        GAP_LIMIT = GAP_W'(TIMEOUT_CYC);
  localparam logic signed [SUM_W-1:0] X_MAX_S   = SUM_W'(X_MAX);
  localparam logic signed [SUM_W-1:0] Y_MAX_S   = SUM_W'(Y_MAX);

  localparam logic [1:0] WAIT_B0 = 2'd0;
  localparam logic [1:0] WAIT_B1 = 2'd1;
  localparam logic [1:0] WAIT_B2 = 2'd2;
  localparam logic [1:0] UPDATE  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [7:0]              status_q, status_d;
  logic [7:0]              xb_q, xb_d;
  logic [7:0]              yb_q, yb_d;
  logic signed [8:0]       x_q, x_d;
  logic signed [8:0]       y_q, y_d;
  logic                    left_q, left_d;
  logic                    right_q, right_d;
  logic                    pkt_q, pkt_d;

  logic signed [8:0]       dx_raw_c, dy_raw_c;
  logic signed [8:0]       dx_c, dy_c;
  logic signed [SUM_W-1:0] sum_x_c, sum_y_c;
  logic                    timeout_c;
  logic                    status_ok_c;
  logic                    unused_status_c;

  assign unused_status_c = ^status_q[3:2];

  // Deltas from the latched packet; sums are wide enough that nothing wraps before clamping.
  always_comb begin
    dx_raw_c = status_q[6] ? 9'sd0 : $signed({status_q[4], xb_q});
    dy_raw_c = status_q[7] ? 9'sd0 : $signed({status_q[5], yb_q});
`ifdef PS2_DELTA_HALF_EN
    dx_c = dx_raw_c >>> 1;
    dy_c = dy_raw_c >>> 1;
`else
    dx_c = dx_raw_c;
    dy_c = dy_raw_c;
`endif
    sum_x_c = SUM_W'(x_q) + SUM_W'(dx_c);
    sum_y_c = SUM_W'(y_q) - SUM_W'(dy_c);
  end

  assign timeout_c   = ((state_q == WAIT_B1) || (state_q == WAIT_B2)) && (gap_q == GAP_LIMIT);
  assign status_ok_c = rx_valid && rx_data[3];

  // Next-state and datapath; a byte arriving on a timeout cycle is judged as a status byte.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    status_d = status_q;
    xb_d     = xb_q;
    yb_d     = yb_q;
    x_d      = x_q;
    y_d      = y_q;
    left_d   = left_q;
    right_d  = right_q;
    pkt_d    = 1'b0;

    if (timeout_c) begin
      gap_d = '0;
      if (status_ok_c) begin
        status_d = rx_data;
        state_d  = WAIT_B1;
      end else begin
        state_d = WAIT_B0;
      end
    end else begin
      case (state_q)
        WAIT_B0: begin
          gap_d = '0;
          if (status_ok_c) begin
            status_d = rx_data;
            state_d  = WAIT_B1;
          end
        end
        WAIT_B1: begin
          if (rx_valid) begin
            xb_d    = rx_data;
            gap_d   = '0;
            state_d = WAIT_B2;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        WAIT_B2: begin
          if (rx_valid) begin
            yb_d    = rx_data;
            gap_d   = '0;
            state_d = UPDATE;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        default: begin
          gap_d   = '0;
          pkt_d   = 1'b1;
          left_d  = status_q[0];
          right_d = status_q[1];
          state_d = WAIT_B0;
          if (sum_x_c < 0)             x_d = '0;
          else if (sum_x_c > X_MAX_S)  x_d = 9'(X_MAX_S);
          else                         x_d = 9'(sum_x_c);
          if (sum_y_c < 0)             y_d = '0;
          else if (sum_y_c > Y_MAX_S)  y_d = 9'(Y_MAX_S);
          else                         y_d = 9'(sum_y_c);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= WAIT_B0;
      gap_q    <= '0;
      status_q <= '0;
      xb_q     <= '0;
      yb_q     <= '0;
      x_q      <= 9'(X_INIT);
      y_q      <= 9'(Y_INIT);
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      pkt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      status_q <= status_d;
      xb_q     <= xb_d;
      yb_q     <= yb_d;
      x_q      <= x_d;
      y_q      <= y_d;
      left_q   <= left_d;
      right_q  <= right_d;
      pkt_q    <= pkt_d;
    end
  end

  assign PS2_Xdata = x_q;
  assign PS2_Ydata = y_q;
  assign btn_left  = left_q;
  assign btn_right = right_q;
  assign pkt_valid = pkt_q;

endmodule

// File: tb/tb_ps2_mouse_pos.sv
// Bench for ps2_mouse_pos: directed packets plus random packets against a cursor model.
module tb_ps2_mouse_pos;

  localparam int TO = 25000;
  localparam int XM = 63;
  localparam int YM = 63;
  localparam int XI = 32;
  localparam int YI = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic signed [8:0] PS2_Xdata;
  logic signed [8:0] PS2_Ydata;
  logic              btn_left;
  logic              btn_right;
  logic              pkt_valid;

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   pkt_cnt = 0;
  int   exp_pkts = 0;
  int   mx, my;
  logic ml, mr;

  ps2_mouse_pos #(
    .X_MAX(XM), .Y_MAX(YM), .X_INIT(XI), .Y_INIT(YI), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .PS2_Xdata(PS2_Xdata), .PS2_Ydata(PS2_Ydata),
    .btn_left(btn_left), .btn_right(btn_right), .pkt_valid(pkt_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pkt_valid === 1'b1) pkt_cnt++;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_data  = $urandom;
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Cursor model: plain integer arithmetic on the packet fields.
  task automatic model_pkt(input logic [7:0] s, input logic [7:0] xb, input logic [7:0] yb);
    int dx, dy;
    dx = s[6] ? 0 : (s[4] ? int'(xb) - 256 : int'(xb));
    dy = s[7] ? 0 : (s[5] ? int'(yb) - 256 : int'(yb));
`ifdef PS2_DELTA_HALF_EN
    dx = dx >>> 1;
    dy = dy >>> 1;
`endif
    mx = clampi(mx + dx, 0, XM);
    my = clampi(my - dy, 0, YM);
    ml = s[0];
    mr = s[1];
    exp_pkts++;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".x"},     PS2_Xdata, mx);
    chk({tag, ".y"},     PS2_Ydata, my);
    chk({tag, ".left"},  btn_left,  ml);
    chk({tag, ".right"}, btn_right, mr);
  endtask

  // Called right after the third byte's cycle: exact two-cycle latency and a one-cycle pulse.
  task automatic finish_pkt(input string tag, input logic [7:0] s, input logic [7:0] xb, input logic [7:0] yb);
    chk({tag, ".pkt_early"}, pkt_valid, 1'b0);
    tick(1);
    chk({tag, ".pkt"}, pkt_valid, 1'b1);
    model_pkt(s, xb, yb);
    chk_state(tag);
    tick(1);
    chk({tag, ".pkt_len"}, pkt_valid, 1'b0);
  endtask

  task automatic send_pkt(input string tag, input logic [7:0] s, input logic [7:0] xb,
                          input logic [7:0] yb, input int gap);
    send(s);
    tick(gap);
    send(xb);
    tick(gap);
    send(yb);
    finish_pkt(tag, s, xb, yb);
  endtask

  task automatic do_reset(input string tag);
    reset    = 1'b0;
    rx_valid = 1'b0;
    #1;
    mx = XI; my = YI; ml = 1'b0; mr = 1'b0;
    chk_state({tag, ".async"});
    chk({tag, ".pkt"}, pkt_valid, 1'b0);
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  function automatic logic [8:0] rand_delta();
    int d;
    if ($urandom_range(0, 3) != 0) d = int'($urandom_range(0, 40)) - 20;
    else d = int'($urandom_range(0, 511)) - 256;
    return 9'(d);
  endfunction

  initial begin
    logic [7:0] s;
    logic [8:0] dx, dy;
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    mx = XI; my = YI; ml = 1'b0; mr = 1'b0;
    tick(3);
    chk_state("reset");
    chk("reset.pkt", pkt_valid, 1'b0);
    reset = 1'b1;
    tick(2);
    chk_state("reset_rel");

    send_pkt("basic", 8'h09, 8'h05, 8'h03, 0);
    chk("basic.count", pkt_cnt, exp_pkts);

    do_reset("rst1");
    send_pkt("clamp_hi", 8'h08, 8'h64, 8'h00, 1);
    send_pkt("clamp_lo", 8'h18, 8'h9C, 8'h00, 2);

    do_reset("rst2");
    send(8'h00);
    send_pkt("resync", 8'h08, 8'h10, 8'h00, 0);

    do_reset("rst3");
    send(8'h08);
    send(8'h05);
    tick(TO);
    chk("timeout.nopkt", pkt_cnt, exp_pkts);
    send_pkt("timeout", 8'h08, 8'h01, 8'h00, 0);
    send(8'h08);
    send(8'h05);
    tick(TO - 1);
    send(8'h00);
    finish_pkt("pre_timeout", 8'h08, 8'h05, 8'h00);

    do_reset("rst4");
    send_pkt("overflow", 8'h4A, 8'hFF, 8'h00, 0);

    do_reset("rst5");
    send_pkt("neg", 8'h18, 8'hFB, 8'h05, 1);

    // A status-looking byte during the update cycle must be dropped.
    send(8'h08);
    send(8'h03);
    send(8'h00);
    send(8'h09);
    chk("upd_ign.pkt", pkt_valid, 1'b1);
    model_pkt(8'h08, 8'h03, 8'h00);
    chk_state("upd_ign");
    send_pkt("after_upd", 8'h08, 8'h02, 8'h00, 0);

    do_reset("rst6");
    send(8'h18);
    do_reset("mid_pkt");
    send(8'hFB);
    send(8'h05);
    tick(4);
    chk("mid_pkt.nopkt", pkt_cnt, exp_pkts);
    chk_state("mid_pkt.hold");
    do_reset("rst7");

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        send(8'($urandom) & 8'hF7);
        tick($urandom_range(0, 2));
      end
      dx = rand_delta();
      dy = rand_delta();
      s = 8'($urandom);
      s[3] = 1'b1;
      s[4] = dx[8];
      s[5] = dy[8];
      s[6] = ($urandom_range(0, 7) == 0);
      s[7] = ($urandom_range(0, 7) == 0);
      send_pkt("rand", s, dx[7:0], dy[7:0], $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        tick($urandom_range(1, 5));
        chk_state("rand.hold");
      end
    end
    chk("final.count", pkt_cnt, exp_pkts);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
